// File: rtl/div_sched.sv
// Round-robin scheduler sharing one external 5/3 divider between NREQ requesters.
// Optional quotient-overflow saturation is enabled by defining DIV_OVF_CHECK_EN.
module div_sched #(
    parameter int NREQ = 4,
    parameter int XW   = 5,
    parameter int DW   = 3,
    parameter int IDW  = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NREQ-1:0]    req_valid,
    input  logic [NREQ*XW-1:0] req_x,
    input  logic [NREQ*DW-1:0] req_d,
    output logic [NREQ-1:0]    req_ready,
    output logic [XW-1:0]      div_x,
    output logic [DW-1:0]      div_d,
    input  logic [DW-1:0]      div_q,
    input  logic [DW-1:0]      div_r,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [IDW-1:0]     rsp_id,
    output logic [DW-1:0]      rsp_q,
    output logic [DW-1:0]      rsp_r,
    output logic               rsp_dz,
    output logic               rsp_ovf
);

    typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

    state_t          state_q;
    logic [IDW-1:0]  rr_ptr_q;
    logic [XW-1:0]   div_x_q;
    logic [DW-1:0]   div_d_q;
    logic [IDW-1:0]  id_q;
    logic [DW-1:0]   quo_q;
    logic [DW-1:0]   rem_q;
    logic            dz_q;
    logic            ovf_q;
    logic            vld_q;

    logic            found;
    logic [IDW-1:0]  grant;
    logic [IDW-1:0]  rr_ptr_d;
    logic [XW-1:0]   sel_x;
    logic [DW-1:0]   sel_d;
    logic [DW-1:0]   res_q;
    logic [DW-1:0]   res_r;
    logic            res_dz;
    logic            res_ovf;
    int unsigned     idx;

    // First valid requester at or after rr_ptr, wrapping at NREQ-1.
    always_comb begin
        found = 1'b0;
        grant = '0;
        idx   = 0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            idx = 32'(rr_ptr_q) + k;
            if (idx >= NREQ) idx = idx - NREQ;
            if (!found && req_valid[IDW'(idx)]) begin
                found = 1'b1;
                grant = IDW'(idx);
            end
        end
    end

    always_comb begin
        sel_x     = '0;
        sel_d     = '0;
        req_ready = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            if (IDW'(k) == grant) begin
                sel_x = req_x[k*XW +: XW];
                sel_d = req_d[k*DW +: DW];
                req_ready[k] = (state_q == IDLE) && found && !rst;
            end
        end
        rr_ptr_d = (grant == IDW'(NREQ - 1)) ? '0 : grant + 1'b1;
    end

    always_comb begin
        res_q   = div_q;
        res_r   = div_r;
        res_dz  = 1'b0;
        res_ovf = 1'b0;
        if (div_d_q == '0) begin
            res_dz = 1'b1;
            res_q  = '0;
            res_r  = '0;
        end
`ifdef DIV_OVF_CHECK_EN
        else if ((XW+DW)'(div_x_q) >= ((XW+DW)'(div_d_q) << DW)) begin
            res_ovf = 1'b1;
            res_q   = '1;
            res_r   = '0;
        end
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            rr_ptr_q <= '0;
            div_x_q  <= '0;
            div_d_q  <= '0;
            id_q     <= '0;
            quo_q    <= '0;
            rem_q    <= '0;
            dz_q     <= 1'b0;
            ovf_q    <= 1'b0;
            vld_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (found) begin
                        div_x_q  <= sel_x;
                        div_d_q  <= sel_d;
                        id_q     <= grant;
                        rr_ptr_q <= rr_ptr_d;
                        state_q  <= ISSUE;
                    end
                end
                ISSUE: begin
                    quo_q   <= res_q;
                    rem_q   <= res_r;
                    dz_q    <= res_dz;
                    ovf_q   <= res_ovf;
                    vld_q   <= 1'b1;
                    state_q <= RESP;
                end
                RESP: begin
                    if (rsp_ready) begin
                        vld_q   <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign div_x     = div_x_q;
    assign div_d     = div_d_q;
    assign rsp_valid = vld_q;
    assign rsp_id    = id_q;
    assign rsp_q     = quo_q;
    assign rsp_r     = rem_q;
    assign rsp_dz    = dz_q;
    assign rsp_ovf   = ovf_q;

endmodule

// File: tb/tb_div_sched.sv
// Directed bench for div_sched with a behavioural divider on the div_* interface.
module tb_div_sched;

    localparam int NREQ = 4;
    localparam int XW   = 5;
    localparam int DW   = 3;
    localparam int IDW  = 2;

    logic               clk = 1'b0;
    logic               rst;
    logic [NREQ-1:0]    req_valid;
    logic [NREQ*XW-1:0] req_x;
    logic [NREQ*DW-1:0] req_d;
    logic [NREQ-1:0]    req_ready;
    logic [XW-1:0]      div_x;
    logic [DW-1:0]      div_d;
    logic [DW-1:0]      div_q;
    logic [DW-1:0]      div_r;
    logic               rsp_valid;
    logic               rsp_ready;
    logic [IDW-1:0]     rsp_id;
    logic [DW-1:0]      rsp_q;
    logic [DW-1:0]      rsp_r;
    logic               rsp_dz;
    logic               rsp_ovf;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    div_sched #(.NREQ(NREQ), .XW(XW), .DW(DW), .IDW(IDW)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_x(req_x), .req_d(req_d), .req_ready(req_ready),
        .div_x(div_x), .div_d(div_d), .div_q(div_q), .div_r(div_r),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_q(rsp_q), .rsp_r(rsp_r), .rsp_dz(rsp_dz), .rsp_ovf(rsp_ovf)
    );

    // Divider returns all ones on zero divisor so a missing dz override is visible.
    always_comb begin
        if (div_d == '0) begin
            div_q = '1;
            div_r = '1;
        end else begin
            div_q = DW'(int'(div_x) / int'(div_d));
            div_r = DW'(int'(div_x) % int'(div_d));
        end
    end

    typedef struct {
        int id; int x; int d; int q; int r; int dz; int ovf;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic set_req(input int id, input int x, input int d);
        req_x[id*XW +: XW] = XW'(x);
        req_d[id*DW +: DW] = DW'(d);
    endtask

    // Starts just after a negedge with the scheduler in IDLE.
    task automatic do_op(input vec_t v);
        req_valid = '0;
        req_valid[v.id] = 1'b1;
        set_req(v.id, v.x, v.d);
        #1 chk("op_ready", int'(req_ready), 1 << v.id);
        @(negedge clk);
        req_valid = '0;
        #1;
        chk("op_issue_valid", int'(rsp_valid), 0);
        chk("op_div_x", int'(div_x), v.x);
        chk("op_div_d", int'(div_d), v.d);
        @(negedge clk);
        #1;
        chk("op_valid", int'(rsp_valid), 1);
        chk("op_id", int'(rsp_id), v.id);
        chk("op_q", int'(rsp_q), v.q);
        chk("op_r", int'(rsp_r), v.r);
        chk("op_dz", int'(rsp_dz), v.dz);
        chk("op_ovf", int'(rsp_ovf), v.ovf);
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        #1 chk("op_done_valid", int'(rsp_valid), 0);
    endtask

    int fx[4] = '{13, 22, 17, 30};
    int fd[4] = '{3, 5, 6, 7};
    int fq[4] = '{4, 4, 2, 4};
    int fr[4] = '{1, 2, 5, 2};

    initial begin
        vecs.push_back('{id: 0, x: 13, d: 3, q: 4, r: 1, dz: 0, ovf: 0});
        vecs.push_back('{id: 2, x: 9,  d: 0, q: 0, r: 0, dz: 1, ovf: 0});
        vecs.push_back('{id: 1, x: 22, d: 5, q: 4, r: 2, dz: 0, ovf: 0});
        vecs.push_back('{id: 3, x: 7,  d: 7, q: 1, r: 0, dz: 0, ovf: 0});
        vecs.push_back('{id: 1, x: 0,  d: 1, q: 0, r: 0, dz: 0, ovf: 0});
        vecs.push_back('{id: 3, x: 23, d: 4, q: 5, r: 3, dz: 0, ovf: 0});
        vecs.push_back('{id: 0, x: 31, d: 7, q: 4, r: 3, dz: 0, ovf: 0});
        vecs.push_back('{id: 2, x: 31, d: 0, q: 0, r: 0, dz: 1, ovf: 0});
`ifdef DIV_OVF_CHECK_EN
        vecs.push_back('{id: 1, x: 31, d: 2, q: 7, r: 0, dz: 0, ovf: 1});
        vecs.push_back('{id: 2, x: 15, d: 2, q: 7, r: 1, dz: 0, ovf: 0});
        vecs.push_back('{id: 3, x: 8,  d: 1, q: 7, r: 0, dz: 0, ovf: 1});
`endif

        rst       = 1'b1;
        req_valid = '1;
        req_x     = '0;
        req_d     = '0;
        rsp_ready = 1'b0;
        #1;
        chk("rst_ready", int'(req_ready), 0);
        chk("rst_valid", int'(rsp_valid), 0);
        chk("rst_div_x", int'(div_x), 0);
        chk("rst_div_d", int'(div_d), 0);
        chk("rst_id", int'(rsp_id), 0);
        chk("rst_q", int'(rsp_q), 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Fairness: all four requesters valid throughout, grants rotate 0,1,2,3,0.
        for (int i = 0; i < 4; i++) set_req(i, fx[i], fd[i]);
        req_valid = '1;
        rsp_ready = 1'b0;
        for (int n = 0; n < 5; n++) begin
            int e;
            e = n % 4;
            #1 chk("rr_ready", int'(req_ready), 1 << e);
            @(negedge clk);
            #1 chk("rr_issue_ready", int'(req_ready), 0);
            @(negedge clk);
            #1;
            chk("rr_valid", int'(rsp_valid), 1);
            chk("rr_id", int'(rsp_id), e);
            chk("rr_q", int'(rsp_q), fq[e]);
            chk("rr_r", int'(rsp_r), fr[e]);
            rsp_ready = 1'b1;
            #1 chk("rr_hs_ready", int'(req_ready), 0);
            @(negedge clk);
            rsp_ready = 1'b0;
        end
        req_valid = '0;

        // Backpressure: rr_ptr is 1 here, so requester 1 alone gets the grant.
        req_valid = 4'b0010;
        set_req(1, 22, 5);
        #1 chk("bp_ready", int'(req_ready), 4'b0010);
        @(negedge clk);
        req_valid = 4'b1101;
        #1 chk("bp_issue_ready", int'(req_ready), 0);
        @(negedge clk);
        for (int c = 0; c < 5; c++) begin
            #1;
            chk("bp_valid", int'(rsp_valid), 1);
            chk("bp_id", int'(rsp_id), 1);
            chk("bp_q", int'(rsp_q), 4);
            chk("bp_r", int'(rsp_r), 2);
            chk("bp_ready_held", int'(req_ready), 0);
            @(negedge clk);
        end
        rsp_ready = 1'b1;
        #1 chk("bp_hs_ready", int'(req_ready), 0);
        @(negedge clk);
        rsp_ready = 1'b0;
        #1;
        chk("bp_idle_valid", int'(rsp_valid), 0);
        chk("bp_next_grant", int'(req_ready), 4'b0100);
        req_valid = '0;
        #1 chk("idle_no_req", int'(req_ready), 0);
        @(negedge clk);
        #1 chk("idle_stays", int'(rsp_valid), 0);

        // Reset during ISSUE discards the operation.
        req_valid = 4'b0001;
        set_req(0, 13, 3);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("mid_rst_valid", int'(rsp_valid), 0);
        chk("mid_rst_ready", int'(req_ready), 0);
        chk("mid_rst_div_x", int'(div_x), 0);
        @(negedge clk);
        rst = 1'b0;
        req_valid = '0;
        for (int c = 0; c < 3; c++) begin
            #1 chk("mid_rst_no_rsp", int'(rsp_valid), 0);
            @(negedge clk);
        end
        do_op('{id: 0, x: 7, d: 7, q: 1, r: 0, dz: 0, ovf: 0});

        foreach (vecs[i]) do_op(vecs[i]);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/div_sched.md
Name: div_sched

Overview:
- Round-robin scheduler that shares one combinational 5/3 restoring divider between NREQ requesters.
- Arbitrates requests and registers the winning operands onto the divider inputs.
- Captures quotient/remainder one cycle later and returns them with the requester ID over a valid/ready response channel.
- Sits between the requester blocks and the single divider instance; the divider itself is external to this block.

Parameters:
- NREQ, 4, number of requesters (2..8).
- XW, 5, dividend width; must match the divider.
- DW, 3, divisor width; also quotient and remainder width.
- IDW, 2, requester ID width; must equal ceil(log2(NREQ)).

Ports:
- clk  in  1  clock, rising-edge.
- rst  in  1  reset, asynchronous, active-high.
- req_valid  in  NREQ  per-requester request valid.
- req_x  in  NREQ*XW  packed dividends; requester i occupies [i*XW +: XW].
- req_d  in  NREQ*DW  packed divisors; requester i occupies [i*DW +: DW].
- req_ready  out  NREQ  one-hot accept strobe.
- div_x  out  XW  registered dividend to the divider.
- div_d  out  DW  registered divisor to the divider.
- div_q  in  DW  divider quotient (combinational from div_x/div_d).
- div_r  in  DW  divider remainder.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  response consumer ready.
- rsp_id  out  IDW  requester index of the response.
- rsp_q  out  DW  quotient.
- rsp_r  out  DW  remainder.
- rsp_dz  out  1  divide-by-zero flag.
- rsp_ovf  out  1  quotient overflow flag (see Optional Feature).

Behaviour:
- Reset values (asynchronous): all outputs 0, state IDLE, rr_ptr=0, div_x=0, div_d=0.
- FSM states: IDLE, ISSUE, RESP.
- IDLE:
  - Grant the first i with req_valid[i]=1, searching from rr_ptr upward and wrapping at NREQ-1 to 0.
  - req_ready[grant]=1 combinationally, only in IDLE and only when some req_valid is set; all other req_ready bits are 0.
  - On accept at the clock edge: latch div_x/div_d and the ID, rr_ptr<=grant+1 (mod NREQ), go to ISSUE.
- ISSUE:
  - Divider settles during this cycle.
  - At the edge, capture rsp_q/rsp_r/rsp_dz/rsp_ovf, set rsp_valid=1, go to RESP.
- RESP:
  - Response fields held stable while rsp_valid=1 and rsp_ready=0.
  - On rsp_valid&rsp_ready: rsp_valid<=0, go to IDLE.
  - No new request is accepted in the same cycle as the handshake; the next accept is at the earliest one cycle later.
- Latency: accept edge to rsp_valid is 2 edges. Throughput is at best one op per 3 cycles.
- Requester rule: req_valid/req_x/req_d are held until req_ready. The scheduler samples them only on the accept cycle and does not check this rule.
- Divisor 0: rsp_dz=1, rsp_q=0, rsp_r=0, divider outputs ignored. Timing is unchanged (still 2 edges).
- Non-requesting inputs and inputs in non-IDLE states are ignored.
- div_x/div_d hold their last value outside of accepts.
- Reset mid-operation: the in-flight op is discarded and no response is produced.
- With no req_valid in IDLE: stay in IDLE, req_ready=0.

Optional Feature:
- Macro: DIV_OVF_CHECK_EN.
- Defined: overflow is detected when X >= (D << DW) with D != 0, i.e. the quotient does not fit in DW bits.
  - On overflow: rsp_ovf=1, rsp_q saturated to all ones (7), rsp_r=0.
  - Divide-by-zero takes priority: rsp_dz=1, rsp_ovf=0.
- Undefined: rsp_ovf is tied to 0 and rsp_q/rsp_r pass raw divider outputs. The bench does not check q/r for overflowing operands in this build.

Test Plan:
- Single op: req_valid=0001, X=13, D=3 → req_ready=0001 for 1 cycle; 2 edges later rsp_valid=1, id=0, q=4, r=1, dz=0.
- Fairness: all four requesters valid continuously with distinct operands → grants in order 0,1,2,3,0; each response carries the matching id and correct q/r; rr_ptr wraps 3→0.
- Divide by zero: requester 2 sends X=9, D=0 → id=2, dz=1, q=0, r=0, ovf=0.
- Backpressure: X=22, D=5 with rsp_ready=0 for 5 cycles → rsp fields stable at q=4, r=2; req_ready stays 0 despite other valid requests; the handshake on cycle 6 returns to IDLE.
- Reset mid-op: assert rst in the ISSUE cycle → rsp_valid and req_ready drop to 0 immediately, no response appears; after release, requester 0 with X=7, D=7 → q=1, r=0.
- Overflow, with DIV_OVF_CHECK_EN defined: X=31, D=2 → ovf=1, q=7, r=0. X=15, D=2 → ovf=0, q=7, r=1.
